// File: rtl/load_store_unit.sv
// Load/store unit: memory-access stage after the ALU. Drives the data-memory
// request/grant/response handshake, aligns store lanes and extends load data.
// Datapath width comes from `BIT_COUNT (32 or 64, default 32).
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- misaligned ops complete at
// once with Exception/ExceptionAddr instead of being aligned down.
`ifndef BIT_COUNT
`define BIT_COUNT 32
`endif

module load_store_unit (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      InValid,
  output logic                      InReady,
  input  logic                      InStore,
  input  logic [2:0]                Funct3,
  input  logic [`BIT_COUNT-1:0]     AluResult,
  input  logic [`BIT_COUNT-1:0]     StoreData,
  input  logic [4:0]                InRd,
  input  logic                      Flush,
  output logic                      Busy,
  output logic                      DmemReq,
  output logic                      DmemWe,
  output logic [`BIT_COUNT-1:0]     DmemAddr,
  output logic [`BIT_COUNT-1:0]     DmemWData,
  output logic [`BIT_COUNT/8-1:0]   DmemByteEn,
  input  logic                      DmemGnt,
  input  logic                      DmemRValid,
  input  logic [`BIT_COUNT-1:0]     DmemRData,
  output logic                      OutValid,
  output logic [4:0]                OutRd,
  output logic [`BIT_COUNT-1:0]     LoadResult,
  output logic                      Exception,
  output logic [`BIT_COUNT-1:0]     ExceptionAddr
);

  localparam int unsigned BW    = `BIT_COUNT;
  localparam int unsigned NB    = BW / 8;
  localparam int unsigned OFS   = $clog2(NB);
  localparam bit          HAS_D = (BW == 64);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  state_t            r_state, w_next_state;
  logic              r_we, r_uns, r_squash;
  logic [BW-1:0]     r_addr, r_wdata, r_lresult;
  logic [NB-1:0]     r_be;
  logic [OFS-1:0]    r_off;
  logic [1:0]        r_size;
  logic [4:0]        r_rd;

  logic              w_accept, w_out_valid;
  logic [1:0]        w_size;
  logic [OFS-1:0]    w_off_raw, w_lowmask, w_off;
  logic [NB-1:0]     w_mask, w_be;
  logic [BW-1:0]     w_wdata, w_raw, w_ext;
`ifdef LSU_MISALIGN_TRAP_EN
  logic              r_exc;
  logic [BW-1:0]     r_exc_addr;
  logic              w_misalign;
`endif

  // Accept-side decode: access size, lane offset, byte enables and store data
  always_comb begin
    w_size    = (Funct3[1:0] == 2'b11 && !HAS_D) ? 2'b10 : Funct3[1:0];
    w_off_raw = AluResult[OFS-1:0];
    w_lowmask = '0;
    w_mask    = '0;
    unique case (w_size)
      2'd0: begin w_lowmask = '0;           w_mask = NB'(1);     end
      2'd1: begin w_lowmask = OFS'(3'd1);   w_mask = NB'(3);     end
      2'd2: begin w_lowmask = OFS'(3'd3);   w_mask = NB'(15);    end
      2'd3: begin w_lowmask = OFS'(3'd7);   w_mask = '1;         end
    endcase
    w_off    = w_off_raw & ~w_lowmask;
    w_be     = w_mask << w_off;
    w_wdata  = StoreData << {w_off, 3'b000};
    w_accept = InValid & (r_state == S_IDLE) & ~Flush;
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = |(w_off_raw & w_lowmask);
`endif
  end

  // Load data: shift the addressed lanes down, then sign- or zero-extend
  always_comb begin
    w_raw = DmemRData >> {r_off, 3'b000};
    unique case (r_size)
      2'd0:    w_ext = r_uns ? BW'(w_raw[7:0])  : BW'($signed(w_raw[7:0]));
      2'd1:    w_ext = r_uns ? BW'(w_raw[15:0]) : BW'($signed(w_raw[15:0]));
      2'd2:    w_ext = r_uns ? BW'(w_raw[31:0]) : BW'($signed(w_raw[31:0]));
      default: w_ext = w_raw;
    endcase
  end

  // State register and per-op captured fields
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_we      <= 1'b0;
      r_uns     <= 1'b0;
      r_squash  <= 1'b0;
      r_addr    <= '0;
      r_wdata   <= '0;
      r_lresult <= '0;
      r_be      <= '0;
      r_off     <= '0;
      r_size    <= '0;
      r_rd      <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      r_exc      <= 1'b0;
      r_exc_addr <= '0;
`endif
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_we     <= InStore;
        r_uns    <= Funct3[2];
        r_squash <= 1'b0;
        r_addr   <= {AluResult[BW-1:OFS], {OFS{1'b0}}};
        r_wdata  <= w_wdata;
        r_be     <= w_be;
        r_off    <= w_off;
        r_size   <= w_size;
        r_rd     <= InRd;
`ifdef LSU_MISALIGN_TRAP_EN
        r_exc      <= w_misalign;
        r_exc_addr <= AluResult;
`endif
      end else if ((r_state == S_REQ || r_state == S_WAIT) && Flush) begin
        r_squash <= 1'b1;
      end
      if (r_state == S_WAIT && DmemRValid) r_lresult <= w_ext;
    end
  end

  // Next state and output decode
  always_comb begin
    w_next_state  = r_state;
    InReady       = 1'b0;
    DmemReq       = 1'b0;
    w_out_valid   = 1'b0;
    OutRd         = '0;
    LoadResult    = '0;
    Exception     = 1'b0;
    ExceptionAddr = '0;
    unique case (r_state)
      S_IDLE: begin
        InReady = 1'b1;
`ifdef LSU_MISALIGN_TRAP_EN
        if (w_accept) w_next_state = w_misalign ? S_DONE : S_REQ;
`else
        if (w_accept) w_next_state = S_REQ;
`endif
      end
      S_REQ: begin
        DmemReq = 1'b1;
        if (DmemGnt)    w_next_state = r_we ? S_DONE : S_WAIT;
        else if (Flush) w_next_state = S_IDLE;
      end
      S_WAIT: begin
        if (DmemRValid) w_next_state = (r_squash || Flush) ? S_IDLE : S_DONE;
      end
      S_DONE: begin
        w_next_state = S_IDLE;
        w_out_valid  = ~r_squash & ~Flush;
      end
    endcase
`ifdef LSU_MISALIGN_TRAP_EN
    Exception     = w_out_valid & r_exc;
    ExceptionAddr = Exception ? r_exc_addr : '0;
    if (w_out_valid && !r_we && !r_exc) begin
`else
    if (w_out_valid && !r_we) begin
`endif
      OutRd      = r_rd;
      LoadResult = r_lresult;
    end
    Busy       = ~InReady;
    OutValid   = w_out_valid;
    DmemWe     = DmemReq & r_we;
    DmemAddr   = r_addr;
    DmemWData  = r_wdata;
    DmemByteEn = r_be;
  end

endmodule
